// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
//   Round-robin arbiter sharing one synchronous-read ROM port among NREQ
//   requesters. A request is accepted with a single-cycle one-hot ready, the
//   ROM is addressed in the same cycle, and the registered ROM data comes back
//   one cycle later tagged by a one-hot rsp_valid_o.
//
// Ports
//   clk_i        clock, all state on posedge
//   rst_i        asynchronous active-high reset
//   req_valid_i  [NREQ]     per-requester read request
//   req_addr_i   [NREQ*AW]  requester i address at [i*AW +: AW]
//   req_ready_o  [NREQ]     one-hot accept (same cycle as grant)
//   rom_en_o                ROM read enable
//   rom_addr_o   [AW]       address to ROM (0 when idle)
//   rom_dout_i   [DW]       ROM registered read data
//   rsp_valid_o  [NREQ]     one-hot owner of rsp_data_o this cycle
//   rsp_data_o   [DW]       read data, pass-through of rom_dout_i

module rom_read_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 2,
    parameter int DW   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*AW-1:0]   req_addr_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 rom_en_o,
    output logic [AW-1:0]        rom_addr_o,
    input  logic [DW-1:0]        rom_dout_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [DW-1:0]        rsp_data_o
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] rsp_valid_q;

    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;

    // Search starts at rr_ptr_q and wraps; explicit wrap keeps non-power-of-2
    // NREQ from ever producing an index >= NREQ.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && req_valid_i[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        int gi;
        gi          = int'(gnt_idx);
        req_ready_o = '0;
        rom_addr_o  = '0;
        rr_ptr_d    = rr_ptr_q;
        if (gnt_found) begin
            req_ready_o[gi] = 1'b1;
            rom_addr_o      = req_addr_i[gi*AW +: AW];
            rr_ptr_d        = (gi == NREQ-1) ? '0 : gnt_idx + PW'(1);
        end
    end

    assign rom_en_o = |req_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= req_ready_o;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rom_dout_i;

endmodule

// File: tb/tb_rom_read_arbiter.sv
module tb_rom_read_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] rom_mem [4];

    // NREQ=4 instance
    logic [3:0] req_valid = '0;
    logic [7:0] req_addr  = '0;
    logic [3:0] req_ready, rsp_valid;
    logic       rom_en;
    logic [1:0] rom_addr;
    logic [7:0] rom_dout = '0, rsp_data;

    // NREQ=3 instance
    logic [2:0] v3 = '0;
    logic [5:0] a3 = '0;
    logic [2:0] rdy3, rsp3;
    logic       en3;
    logic [1:0] addr3;
    logic [7:0] dout3 = '0, data3;

    rom_read_arbiter #(.NREQ(4), .AW(2), .DW(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_ready_o(req_ready), .rom_en_o(rom_en), .rom_addr_o(rom_addr),
        .rom_dout_i(rom_dout), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data));

    rom_read_arbiter #(.NREQ(3), .AW(2), .DW(8)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(v3), .req_addr_i(a3),
        .req_ready_o(rdy3), .rom_en_o(en3), .rom_addr_o(addr3),
        .rom_dout_i(dout3), .rsp_valid_o(rsp3), .rsp_data_o(data3));

    // Bench ROMs: registered read, one-cycle latency
    always @(posedge clk) begin
        if (rom_en) rom_dout <= rom_mem[rom_addr];
        if (en3)    dout3    <= rom_mem[addr3];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [7:0] a;
        logic [3:0] rdy;
        logic [1:0] raddr;
    } vec_t;

    typedef struct {
        logic [3:0] v;
        logic [7:0] d;
    } rsp_t;

    rsp_t sb[$];
    int   mptr;

    function automatic int model_gnt(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (p + k) % 4;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic sb_reset();
        rsp_t e;
        e.v = '0;
        e.d = '0;
        sb.delete();
        sb.push_back(e);
        mptr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        v3 = '0;
        #1;
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rom_en", {31'd0, rom_en}, 32'd0);
        chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_reset();
    endtask

    // Called at negedge: checks this cycle's comb outputs against the vector,
    // the response against the scoreboard, and pushes next cycle's response.
    task automatic check_cycle(input string tag, input logic [3:0] exp_rdy, input logic [1:0] exp_addr);
        rsp_t e, n;
        int g;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rsp_valid"}, {28'd0, rsp_valid}, {28'd0, e.v});
            if (e.v != '0) chk({tag, "_rsp_data"}, {24'd0, rsp_data}, {24'd0, e.d});
        end
        chk({tag, "_ptr"}, {30'd0, u_dut.rr_ptr_q}, mptr);
        chk({tag, "_ready"}, {28'd0, req_ready}, {28'd0, exp_rdy});
        chk({tag, "_rom_en"}, {31'd0, rom_en}, {31'd0, |exp_rdy});
        chk({tag, "_rom_addr"}, {30'd0, rom_addr}, {30'd0, exp_addr});
        g = model_gnt(req_valid, mptr);
        n.v = '0;
        n.d = '0;
        if (g >= 0) begin
            n.v[g] = 1'b1;
            n.d    = rom_mem[req_addr[g*2 +: 2]];
            mptr   = (g == 3) ? 0 : g + 1;
        end
        sb.push_back(n);
    endtask

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic [3:0] v, logic [7:0] a, logic [3:0] rdy, logic [1:0] ra);
        vec_t x;
        x.rst = r; x.v = v; x.a = a; x.rdy = rdy; x.raddr = ra;
        return x;
    endfunction

    initial begin
        rom_mem[0] = 8'h2F; rom_mem[1] = 8'h20; rom_mem[2] = 8'hEF; rom_mem[3] = 8'hFF;

        // single grant from reset: req2 addr2
        tv.push_back(mk(1, 4'b0100, 8'h20, 4'b0100, 2'd2));
        tv.push_back(mk(0, 4'b0000, 8'h00, 4'b0000, 2'd0));
        // all valid, addr_i = i
        tv.push_back(mk(1, 4'b1111, 8'hE4, 4'b0001, 2'd0));
        tv.push_back(mk(0, 4'b1111, 8'hE4, 4'b0010, 2'd1));
        tv.push_back(mk(0, 4'b1111, 8'hE4, 4'b0100, 2'd2));
        tv.push_back(mk(0, 4'b1111, 8'hE4, 4'b1000, 2'd3));
        tv.push_back(mk(0, 4'b1111, 8'hE4, 4'b0001, 2'd0));
        tv.push_back(mk(0, 4'b0000, 8'hE4, 4'b0000, 2'd0));
        // bring ptr to 3, then req1+req3: 3 first, then wrap to 1
        tv.push_back(mk(1, 4'b0100, 8'h20, 4'b0100, 2'd2));
        tv.push_back(mk(0, 4'b1010, 8'hC4, 4'b1000, 2'd3));
        tv.push_back(mk(0, 4'b0010, 8'hC4, 4'b0010, 2'd1));
        // idle cycles: pointer holds at 2
        tv.push_back(mk(0, 4'b0000, 8'h00, 4'b0000, 2'd0));
        tv.push_back(mk(0, 4'b0000, 8'h00, 4'b0000, 2'd0));
        // single requester granted every cycle
        tv.push_back(mk(0, 4'b0001, 8'h03, 4'b0001, 2'd3));
        tv.push_back(mk(0, 4'b0001, 8'h03, 4'b0001, 2'd3));
        tv.push_back(mk(0, 4'b0001, 8'h03, 4'b0001, 2'd3));
        tv.push_back(mk(0, 4'b0000, 8'h00, 4'b0000, 2'd0));
        tv.push_back(mk(0, 4'b0000, 8'h00, 4'b0000, 2'd0));

        mptr = 0;
        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rst) do_reset();
            @(posedge clk); #1;
            req_valid = tv[i].v;
            req_addr  = tv[i].a;
            @(negedge clk);
            check_cycle($sformatf("vec%0d", i), tv[i].rdy, tv[i].raddr);
        end

        // Async reset the cycle after a grant: response discarded
        do_reset();
        @(posedge clk); #1;
        req_valid = 4'b0001; req_addr = 8'h00;
        @(negedge clk);
        chk("ar_ready", {28'd0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        chk("ar_rsp_before", {28'd0, rsp_valid}, 32'h1);
        chk("ar_data_before", {24'd0, rsp_data}, 32'h2F);
        rst = 1'b1;
        #1;
        chk("ar_rsp_async", {28'd0, rsp_valid}, 32'h0);
        chk("ar_ptr_async", {30'd0, u_dut.rr_ptr_q}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ar_no_rsp", {28'd0, rsp_valid}, 32'h0);
            chk("ar_ptr_hold", {30'd0, u_dut.rr_ptr_q}, 32'h0);
        end

        // NREQ=3: order 0,1,2,0,1,2 and pointer wraps 2->0
        do_reset();
        begin
            logic [2:0] prev;
            int pidx;
            prev = '0;
            pidx = 0;
            for (int k = 0; k < 6; k++) begin
                logic [2:0] exp;
                @(posedge clk); #1;
                v3 = 3'b111;
                a3 = 6'b100100;
                @(negedge clk);
                exp = 3'b001 << (k % 3);
                chk("n3_ptr", {30'd0, u_dut3.rr_ptr_q}, k % 3);
                chk("n3_ready", {29'd0, rdy3}, {29'd0, exp});
                chk("n3_rom_addr", {30'd0, addr3}, k % 3);
                chk("n3_rsp_valid", {29'd0, rsp3}, {29'd0, prev});
                if (prev != '0) chk("n3_rsp_data", {24'd0, data3}, {24'd0, rom_mem[pidx]});
                prev = exp;
                pidx = k % 3;
            end
            @(posedge clk); #1;
            v3 = '0;
            @(negedge clk);
            chk("n3_last_rsp", {29'd0, rsp3}, {29'd0, prev});
            chk("n3_last_data", {24'd0, data3}, {24'd0, rom_mem[pidx]});
            @(negedge clk);
            chk("n3_idle_rsp", {29'd0, rsp3}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
